// File: rtl/bcd_pkg.sv
// Shared widths and FSM encoding for the arbitrated binary-to-BCD converter.
package bcd_pkg;
    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;
    localparam int BCD_W  = 20;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_conv_arb_if.sv
// Two request channels, one response channel and FSM visibility for the converter.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high.
interface bcd_conv_arb_if;
    import bcd_pkg::*;

    logic             req0_valid;
    logic [BIN_W-1:0] req0_bin;
    logic             req0_ready;
    logic             req1_valid;
    logic [BIN_W-1:0] req1_bin;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [BCD_W-1:0] rsp_bcd;
    logic             rsp_id;
    logic             busy;
    state_t           state;

    modport master (
        output req0_valid, req0_bin, req1_valid, req1_bin, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_bcd, rsp_id, busy, state
    );

    modport slave (
        input  req0_valid, req0_bin, req1_valid, req1_bin, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_bcd, rsp_id, busy, state
    );
endinterface

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift left taking bit_in.
module bcd_dd_step
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digits,
    input  logic             bit_in,
    output logic [BCD_W-1:0] next_digits
);
    // The MSB of the adjusted chain is shifted out; it is always 0 for 16-bit operands.
    logic [BCD_W-2:0] adj;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (i < DIGITS - 1) begin : g_full
            logic [3:0] d;
            assign d = (digits[4*i +: 4] >= 4'd5) ? digits[4*i +: 4] + 4'd3 : digits[4*i +: 4];
            assign adj[4*i +: 4] = d;
        end else begin : g_top
            assign adj[4*i +: 3] = digits[4*i +: 3] + ((digits[4*i +: 4] >= 4'd5) ? 3'd3 : 3'd0);
        end
    end

    assign next_digits = {adj, bit_in};
endmodule

// File: rtl/bcd_conv_arb.sv
// Round-robin arbiter in front of a sequential 16-bit binary to 5-digit BCD converter.
module bcd_conv_arb
    import bcd_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    bcd_conv_arb_if.slave  bus
);
    state_t           state;
    logic [BIN_W-1:0] operand;
    logic [BCD_W-1:0] digits;
    logic [BCD_W-1:0] next_digits;
    logic [CNT_W-1:0] cnt;
    logic             prio;
    logic             cur_id;
    logic             rsp_valid_q;
    logic             busy_q;
    logic             grant0;
    logic             grant1;
    logic             accept;

    // prio = 1 means requester 1 wins a tie; gated by rst so ready is low in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = ~prio;
                grant1 = prio;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept = grant0 | grant1;

    bcd_dd_step u_step (
        .digits      (digits),
        .bit_in      (operand[cnt]),
        .next_digits (next_digits)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            operand     <= '0;
            digits      <= '0;
            cnt         <= '0;
            prio        <= 1'b0;
            cur_id      <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        operand <= grant1 ? bus.req1_bin : bus.req0_bin;
                        cur_id  <= grant1;
                        digits  <= '0;
                        cnt     <= CNT_W'(BIN_W - 1);
                        prio    <= ~grant1;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    digits <= next_digits;
                    if (cnt == '0) begin
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_bcd    = rsp_valid_q ? digits : '0;
    assign bus.rsp_id     = rsp_valid_q & cur_id;
    assign bus.busy       = busy_q;
    assign bus.state      = state;
endmodule

// File: doc/bcd_conv_arb.md
BCD_CONV_ARB -- requirements
Module: bcd_conv_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 req0_valid  input  1  requester 0 has a 16-bit binary value to convert.
REQ-005 req0_bin  input  16  requester 0 unsigned binary operand.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 req1_valid / req1_bin / req1_ready SHALL be identical to REQ-004..006 for requester 1.
REQ-008 rsp_valid  output  1  conversion result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_bcd  output  20  five packed BCD digits, [19:16] = ten-thousands … [3:0] = ones.
REQ-011 rsp_id  output  1  requester index that owns rsp_bcd.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, exactly one reqN_ready SHALL be high, and only when reqN_valid is high; the grant is combinational from the valid inputs and the priority pointer.
REQ-015 Arbitration SHALL be round-robin.
- Both valid: grant the requester not granted last.
- One valid: grant that requester.
- The pointer resets to favour requester 0.
REQ-016 On an accepting edge (valid & ready in IDLE), the block SHALL:
- latch the operand and the requester id;
- clear all digit registers;
- load the bit counter with 15;
- update the priority pointer;
- enter SHIFT.
REQ-017 Each SHIFT cycle SHALL perform one double-dabble step, MSB first:
- every digit >= 5 gets +3;
- then the 20-bit digit chain shifts left by one, with operand bit [counter] entering bit 0.
REQ-018 SHIFT SHALL last exactly 16 cycles; the edge that processes bit 0 enters DONE.
REQ-019 rsp_valid SHALL rise on the 16th edge after the accepting edge, and SHALL be high only in DONE.
REQ-020 While rsp_valid is high and rsp_ready is low, rsp_bcd and rsp_id SHALL hold stable.
REQ-021 DONE with rsp_ready high SHALL return to IDLE. No new request is accepted in that same cycle, so the minimum period is 18 cycles per conversion.
REQ-022 reqN_ready SHALL be low in SHIFT and DONE. Requests arriving then are neither lost nor acknowledged: the requester holds valid until a later IDLE grant.
REQ-023 rsp_bcd SHALL be exact for every input 0..65535; no truncation and no overflow is possible with five digits.
REQ-024 rsp_bcd SHALL be 0 when rsp_valid is low.
REQ-025 A requester dropping valid without a handshake SHALL NOT affect the FSM.

Reset
REQ-026 Asserting rst (0) SHALL immediately force the following, regardless of state:
- state = IDLE;
- rsp_valid = 0, rsp_bcd = 0, rsp_id = 0, busy = 0;
- both ready = 0;
- counter = 0;
- priority pointer favouring requester 0.
REQ-027 A conversion interrupted by reset SHALL be discarded with no response. Operation resumes on the first clk edge after rst returns to 1.

Structure
REQ-028 Package bcd_pkg SHALL hold shared definitions:
- BIN_W = 16;
- DIGITS = 5;
- BCD_W = 20;
- CNT_W = 4;
- the state enumeration {IDLE, SHIFT, DONE}.
REQ-029 The add-3-then-shift step SHALL live in one combinational sub-module, bcd_dd_step.
- Inputs: 20-bit digits and 1 new bit.
- Output: the next 20-bit digits.
- It is instantiated once; the arbiter, FSM and counter remain in bcd_conv_arb.

Verification
REQ-030 req0 = 0 -> rsp_bcd = 0x00000, rsp_id = 0, rsp_valid rises 16 edges after the accept.
REQ-031 req1 = 65535 -> rsp_bcd = 0x65535, rsp_id = 1; and req0 = 9999 -> rsp_bcd = 0x09999.
REQ-032 Both valid from reset with req0 = 1234 and req1 = 4321 -> first response is 0x01234 with id 0, then 0x04321 with id 1. Both held continuously afterwards -> grants alternate 0,1,0,1.
REQ-033 rsp_ready low for 5 cycles in DONE -> rsp_valid, rsp_bcd and rsp_id stable throughout; return to IDLE on the edge where rsp_ready = 1.
REQ-034 rst driven low at SHIFT cycle 8 of converting 500 -> all outputs 0 immediately; no response for 500. After release, req0 = 500 -> 0x00500.
REQ-035 req1_valid raised during SHIFT -> req1_ready stays low until IDLE, then is granted.
